// File: rtl/sd_pulse_quantizer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sd_pulse_quantizer                                         |
// | Description : SDFP loop output stage. Quantizes the signed loop-filter   |
// |               sum into mutually exclusive P/Q leg commands, with a       |
// |               minimum on-time per pulse and a dead time on every leg     |
// |               turn-off.                                                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sd_pulse_quantizer #(
    parameter int IN_WIDTH  = 16,
    parameter int TH_HI     = 256,
    parameter int TH_LO     = -256,
    parameter int MIN_ON    = 4,
    parameter int DEAD_CYC  = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_en,
    input  logic [IN_WIDTH-1:0] loop_in,
    output logic                out_P,
    output logic                out_Q,
    output logic                busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_P_ON = 2'd1,
        ST_Q_ON = 2'd2,
        ST_DEAD = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_P    = 2'd1,
        REQ_Q    = 2'd2
    } req_t;

    // Thresholds are narrowed to the input width so the compare is a plain
    // signed compare of equal-width operands.
    localparam logic signed [IN_WIDTH-1:0]  c_th_hi    = IN_WIDTH'(TH_HI);
    localparam logic signed [IN_WIDTH-1:0]  c_th_lo    = IN_WIDTH'(TH_LO);
    localparam logic        [CNT_WIDTH-1:0] c_on_max   = CNT_WIDTH'(MIN_ON - 1);
    localparam logic        [CNT_WIDTH-1:0] c_dead_max = CNT_WIDTH'(DEAD_CYC - 1);
    localparam logic        [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);
    localparam logic        [CNT_WIDTH-1:0] c_cnt_zero = '0;

    state_t                 r_state;
    req_t                   r_target;
    logic [CNT_WIDTH-1:0]   r_on_cnt;
    logic [CNT_WIDTH-1:0]   r_dead_cnt;
    logic                   r_out_p;
    logic                   r_out_q;
    logic                   r_busy;

    logic signed [IN_WIDTH-1:0] w_loop_s;
    req_t                   w_req;
    req_t                   w_own;
    state_t                 w_state_nxt;
    req_t                   w_target_nxt;
    logic [CNT_WIDTH-1:0]   w_on_nxt;
    logic [CNT_WIDTH-1:0]   w_dead_nxt;

    assign w_loop_s = $signed(loop_in);

    // Quantizer decision: P above the high threshold, Q below the low one.
    always_comb begin
        w_req = REQ_NONE;
        if (w_loop_s >= c_th_hi) begin
            w_req = REQ_P;
        end else if (w_loop_s <= c_th_lo) begin
            w_req = REQ_Q;
        end
    end

    // Next-state logic; counters hold unless explicitly advanced.
    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_on_nxt     = r_on_cnt;
        w_dead_nxt   = r_dead_cnt;
        w_own        = (r_state == ST_P_ON) ? REQ_P : REQ_Q;
        case (r_state)
            ST_IDLE: begin
                if (sample_en && (w_req == REQ_P)) begin
                    w_state_nxt = ST_P_ON;
                    w_on_nxt    = c_cnt_zero;
                end else if (sample_en && (w_req == REQ_Q)) begin
                    w_state_nxt = ST_Q_ON;
                    w_on_nxt    = c_cnt_zero;
                end
            end
            ST_P_ON, ST_Q_ON: begin
                if (sample_en) begin
                    if (r_on_cnt < c_on_max) begin
                        // Still inside the minimum on-time: decision ignored.
                        w_on_nxt = r_on_cnt + c_cnt_one;
                    end else if (w_req != w_own) begin
                        // Leg turns off; the request (NONE or the opposite
                        // leg) becomes what follows the dead time.
                        w_state_nxt  = ST_DEAD;
                        w_target_nxt = w_req;
                        w_dead_nxt   = c_dead_max;
                    end
                end
            end
            ST_DEAD: begin
                // Dead time runs on clk, independent of sample_en.
                if (r_dead_cnt == c_cnt_zero) begin
                    w_on_nxt = c_cnt_zero;
                    case (r_target)
                        REQ_P:   w_state_nxt = ST_P_ON;
                        REQ_Q:   w_state_nxt = ST_Q_ON;
                        default: w_state_nxt = ST_IDLE;
                    endcase
                end else begin
                    w_dead_nxt = r_dead_cnt - c_cnt_one;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counters and output registers; reset forces a full dead time.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_DEAD;
            r_target   <= REQ_NONE;
            r_on_cnt   <= c_cnt_zero;
            r_dead_cnt <= c_dead_max;
            r_out_p    <= 1'b0;
            r_out_q    <= 1'b0;
            r_busy     <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_target   <= w_target_nxt;
            r_on_cnt   <= w_on_nxt;
            r_dead_cnt <= w_dead_nxt;
            r_out_p    <= (w_state_nxt == ST_P_ON);
            r_out_q    <= (w_state_nxt == ST_Q_ON);
            r_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

    assign out_P = r_out_p;
    assign out_Q = r_out_q;
    assign busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sd_pulse_quantizer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sd_pulse_quantizer                                      |
// | Description : Directed self-checking bench for sd_pulse_quantizer with   |
// |               default parameters (TH +/-256, MIN_ON 4, DEAD_CYC 8).      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_sd_pulse_quantizer;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_en;
    logic [15:0] loop_in;
    logic        out_P;
    logic        out_Q;
    logic        busy;

    int total = 0;
    int bad   = 0;

    sd_pulse_quantizer #(
        .IN_WIDTH  (16),
        .TH_HI     (256),
        .TH_LO     (-256),
        .MIN_ON    (4),
        .DEAD_CYC  (8),
        .CNT_WIDTH (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sample_en (sample_en),
        .loop_in   (loop_in),
        .out_P     (out_P),
        .out_Q     (out_Q),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Legs must never be on together.
    always @(negedge clk) begin
        if (out_P === 1'b1 || out_Q === 1'b1) begin
            total++;
            if (out_P === 1'b1 && out_Q === 1'b1) begin
                bad++;
                $display("FAIL overlap: got P=%b Q=%b want not both 1", out_P, out_Q);
            end
        end
    end

    // Advance one clock; outputs are then stable for the edge just taken.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle strobe with the given sample.
    task automatic strobe(input logic [15:0] v);
        sample_en = 1'b1;
        loop_in   = v;
        tick();
        sample_en = 1'b0;
        loop_in   = 16'd0;
    endtask

    // Ends a pulse started from IDLE (four zero samples) and waits out dead time.
    task automatic finish_pulse();
        repeat (4) strobe(16'd0);
        repeat (8) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; sample_en = 1'b0; loop_in = 16'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({out_P, out_Q, busy} !== 3'b001) begin
                bad++;
                $display("FAIL reset_hold_%0d: got PQB=%b want 001", i, {out_P, out_Q, busy});
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            total++;
            if ({out_P, out_Q, busy} !== 3'b001) begin
                bad++;
                $display("FAIL reset_dead_%0d: got PQB=%b want 001", i, {out_P, out_Q, busy});
            end
        end
        tick();
        total++;
        if ({out_P, out_Q, busy} !== 3'b000) begin
            bad++;
            $display("FAIL reset_idle: got PQB=%b want 000", {out_P, out_Q, busy});
        end
    endtask

    task automatic test_single_p();
        strobe(16'd300);
        total++;
        if ({out_P, out_Q, busy} !== 3'b101) begin
            bad++;
            $display("FAIL single_rise: got PQB=%b want 101", {out_P, out_Q, busy});
        end
        repeat (3) tick();
        for (int s = 2; s <= 4; s++) begin
            strobe(16'd0);
            total++;
            if ({out_P, out_Q, busy} !== 3'b101) begin
                bad++;
                $display("FAIL single_hold_s%0d: got PQB=%b want 101", s, {out_P, out_Q, busy});
            end
            repeat (3) tick();
        end
        strobe(16'd0);
        total++;
        if ({out_P, out_Q, busy} !== 3'b001) begin
            bad++;
            $display("FAIL single_fall: got PQB=%b want 001", {out_P, out_Q, busy});
        end
        for (int k = 1; k <= 7; k++) begin
            tick();
            total++;
            if ({out_P, out_Q, busy} !== 3'b001) begin
                bad++;
                $display("FAIL single_dead_%0d: got PQB=%b want 001", k, {out_P, out_Q, busy});
            end
        end
        tick();
        total++;
        if ({out_P, out_Q, busy} !== 3'b000) begin
            bad++;
            $display("FAIL single_idle: got PQB=%b want 000", {out_P, out_Q, busy});
        end
    endtask

    task automatic test_thresholds();
        logic [15:0] tv [6];
        logic [2:0]  te [6];
        tv = '{16'd256, 16'd255, 16'hFF00, 16'hFF01, 16'h8000, 16'h7FFF};
        te = '{3'b101,  3'b000,  3'b011,   3'b000,   3'b011,   3'b101};
        for (int i = 0; i < 6; i++) begin
            strobe(tv[i]);
            total++;
            if ({out_P, out_Q, busy} !== te[i]) begin
                bad++;
                $display("FAIL thr_%h: got PQB=%b want %b", tv[i], {out_P, out_Q, busy}, te[i]);
            end
            if (te[i] != 3'b000) finish_pulse();
            total++;
            if ({out_P, out_Q, busy} !== 3'b000) begin
                bad++;
                $display("FAIL thr_%h_idle: got PQB=%b want 000", tv[i], {out_P, out_Q, busy});
            end
        end
    endtask

    task automatic test_reversal();
        strobe(16'd300);
        repeat (4) strobe(16'd300);
        total++;
        if ({out_P, out_Q, busy} !== 3'b101) begin
            bad++;
            $display("FAIL rev_hold: got PQB=%b want 101", {out_P, out_Q, busy});
        end
        strobe(16'hFC18);
        total++;
        if ({out_P, out_Q, busy} !== 3'b001) begin
            bad++;
            $display("FAIL rev_fall: got PQB=%b want 001", {out_P, out_Q, busy});
        end
        for (int k = 1; k <= 7; k++) begin
            tick();
            total++;
            if ({out_P, out_Q, busy} !== 3'b001) begin
                bad++;
                $display("FAIL rev_dead_%0d: got PQB=%b want 001", k, {out_P, out_Q, busy});
            end
        end
        tick();
        total++;
        if ({out_P, out_Q, busy} !== 3'b011) begin
            bad++;
            $display("FAIL rev_q_rise: got PQB=%b want 011", {out_P, out_Q, busy});
        end
        finish_pulse();
        total++;
        if ({out_P, out_Q, busy} !== 3'b000) begin
            bad++;
            $display("FAIL rev_idle: got PQB=%b want 000", {out_P, out_Q, busy});
        end
    endtask

    task automatic test_min_on();
        strobe(16'd300);
        for (int s = 2; s <= 4; s++) begin
            repeat (3) tick();
            strobe(16'hFC18);
            total++;
            if ({out_P, out_Q, busy} !== 3'b101) begin
                bad++;
                $display("FAIL minon_s%0d: got PQB=%b want 101", s, {out_P, out_Q, busy});
            end
        end
        repeat (3) tick();
        strobe(16'hFC18);
        total++;
        if ({out_P, out_Q, busy} !== 3'b001) begin
            bad++;
            $display("FAIL minon_fall: got PQB=%b want 001", {out_P, out_Q, busy});
        end
        repeat (7) tick();
        tick();
        total++;
        if ({out_P, out_Q, busy} !== 3'b011) begin
            bad++;
            $display("FAIL minon_q: got PQB=%b want 011", {out_P, out_Q, busy});
        end
        repeat (4) strobe(16'd0);
        sample_en = 1'b1;
        loop_in   = 16'd1000;
        for (int k = 1; k <= 7; k++) begin
            tick();
            total++;
            if ({out_P, out_Q, busy} !== 3'b001) begin
                bad++;
                $display("FAIL dead_ignore_%0d: got PQB=%b want 001", k, {out_P, out_Q, busy});
            end
        end
        tick();
        total++;
        if ({out_P, out_Q, busy} !== 3'b000) begin
            bad++;
            $display("FAIL dead_expiry: got PQB=%b want 000", {out_P, out_Q, busy});
        end
        tick();
        sample_en = 1'b0;
        loop_in   = 16'd0;
        total++;
        if ({out_P, out_Q, busy} !== 3'b101) begin
            bad++;
            $display("FAIL dead_then_p: got PQB=%b want 101", {out_P, out_Q, busy});
        end
        finish_pulse();
        total++;
        if ({out_P, out_Q, busy} !== 3'b000) begin
            bad++;
            $display("FAIL minon_idle: got PQB=%b want 000", {out_P, out_Q, busy});
        end
    endtask

    task automatic test_back_to_back();
        sample_en = 1'b1;
        loop_in   = 16'd300;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if ({out_P, out_Q, busy} !== 3'b101) begin
                bad++;
                $display("FAIL b2b_on_%0d: got PQB=%b want 101", k, {out_P, out_Q, busy});
            end
        end
        loop_in = 16'd0;
        for (int k = 0; k < 8; k++) begin
            tick();
            total++;
            if ({out_P, out_Q, busy} !== 3'b001) begin
                bad++;
                $display("FAIL b2b_dead_%0d: got PQB=%b want 001", k, {out_P, out_Q, busy});
            end
        end
        tick();
        sample_en = 1'b0;
        total++;
        if ({out_P, out_Q, busy} !== 3'b000) begin
            bad++;
            $display("FAIL b2b_idle: got PQB=%b want 000", {out_P, out_Q, busy});
        end
    endtask

    task automatic test_reset_mid();
        strobe(16'hFC18);
        strobe(16'hFC18);
        total++;
        if ({out_P, out_Q, busy} !== 3'b011) begin
            bad++;
            $display("FAIL rmid_q: got PQB=%b want 011", {out_P, out_Q, busy});
        end
        reset     = 1'b1;
        sample_en = 1'b0;
        loop_in   = 16'hFC18;
        tick();
        total++;
        if ({out_P, out_Q, busy} !== 3'b001) begin
            bad++;
            $display("FAIL rmid_drop: got PQB=%b want 001", {out_P, out_Q, busy});
        end
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            total++;
            if ({out_P, out_Q, busy} !== 3'b001) begin
                bad++;
                $display("FAIL rmid_dead_%0d: got PQB=%b want 001", k, {out_P, out_Q, busy});
            end
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if ({out_P, out_Q, busy} !== 3'b000) begin
                bad++;
                $display("FAIL rmid_idle_%0d: got PQB=%b want 000", k, {out_P, out_Q, busy});
            end
        end
        loop_in = 16'd0;
    endtask

    initial begin
        test_reset();
        test_single_p();
        test_thresholds();
        test_reversal();
        test_min_on();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
